instruction_fetch_unit: RTL and testbench

//  Producer side of the IR_instruction interface: holds the PC, fetches 32-bit words

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit_next_pc_calc.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 79 +++++++
 tb/tb_instruction_fetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: branch-select codes,
// fetch FSM encodings and instruction-word constants.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BS_INC = 2'b00,
        BS_BRZ = 2'b01,
        BS_JMP = 2'b10,
        BS_REL = 2'b11
    } bs_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_ISSUE = 2'b10
    } fetch_state_t;

    // Opcode 7'b0000000 decodes as NOP, so an all-zero IR is harmless
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory handshake, decoder IR hand-off and
// branch-control inputs. master = fetch unit, slave = memory/decoder/datapath side.
interface instruction_fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;
    logic [31:0] ir_instruction;
    logic        ir_valid;
    logic        ex_done;
    logic [1:0]  bs;
    logic        ps;
    logic        z;
    logic [31:0] bus_a;
    logic [31:0] pc;

    modport master (
        output mem_req, mem_addr, ir_instruction, ir_valid, pc,
        input  mem_rdy, mem_data, ex_done, bs, ps, z, bus_a
    );

    modport slave (
        input  mem_req, mem_addr, ir_instruction, ir_valid, pc,
        output mem_rdy, mem_data, ex_done, bs, ps, z, bus_a
    );

endinterface

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: increment, conditional relative branch,
// absolute jump through BUS_A, or unconditional relative branch.
module instruction_fetch_unit_next_pc_calc
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DISP_W = 15
) (
    input  logic [31:0]       pc,
    input  logic [DISP_W-1:0] disp,
    input  logic [1:0]        bs,
    input  logic              ps,
    input  logic              z,
    input  logic [31:0]       bus_a,
    output logic [31:0]       next_pc
);

    logic [31:0] pc_inc;
    logic [31:0] pc_rel;
    logic        taken;

    // Relative targets are measured from the already-incremented PC
    assign pc_inc = pc + 32'd1;
    assign pc_rel = pc_inc + {{(32 - DISP_W){disp[DISP_W-1]}}, disp};
    assign taken  = ps ? ~z : z;

    always_comb begin
        next_pc = pc_inc;
        case (bs_t'(bs))
            BS_INC:  next_pc = pc_inc;
            BS_BRZ:  next_pc = taken ? pc_rel : pc_inc;
            BS_JMP:  next_pc = bus_a;
            BS_REL:  next_pc = pc_rel;
            default: next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/rdy handshake
// and holds IR/IR_VALID stable for the decoder until the datapath reports done.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DISP_W   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] next_pc;
    logic        mem_req_q;
    logic        ir_valid_q;

    instruction_fetch_unit_next_pc_calc #(
        .DISP_W (DISP_W)
    ) u_next_pc_calc (
        .pc      (pc_q),
        .disp    (ir_q[DISP_W-1:0]),
        .bs      (bus.bs),
        .ps      (bus.ps),
        .z       (bus.z),
        .bus_a   (bus.bus_a),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake strobes outside their own state are simply ignored
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (bus.mem_rdy) state_next = S_ISSUE;
            S_ISSUE: if (bus.ex_done) state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they change only on edges
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= NOP_WORD;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            mem_req_q  <= (state_next == S_FETCH);
            ir_valid_q <= (state_next == S_ISSUE);
            if (state == S_FETCH && bus.mem_rdy) begin
                ir_q <= bus.mem_data;
            end
            if (state == S_ISSUE && bus.ex_done) begin
                pc_q <= next_pc;
            end
        end
    end

    assign bus.mem_req        = mem_req_q;
    assign bus.mem_addr       = pc_q;
    assign bus.ir_instruction = ir_q;
    assign bus.ir_valid       = ir_valid_q;
    assign bus.pc             = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit: reset, streaming
// fetch, memory wait states, branch selection, PC wrap and reset abort.
module tb_instruction_fetch_unit;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    instruction_fetch_unit_if mif ();

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DISP_W   (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset low across one edge with all inputs idle, then releases it
    task automatic apply_reset();
        reset        = 1'b0;
        mif.mem_rdy  = 1'b0;
        mif.mem_data = 32'h0;
        mif.ex_done  = 1'b0;
        mif.bs       = 2'b00;
        mif.ps       = 1'b0;
        mif.z        = 1'b0;
        mif.bus_a    = 32'h0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mif.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL wait_req: mem_req got %b after 20 cycles, want 1", mif.mem_req);
        end
    endtask

    // One complete fetch + execute; leaves the unit in FETCH at the new PC
    task automatic issue(input logic [31:0] word, input logic [1:0] bs_v,
                         input logic ps_v, input logic z_v, input logic [31:0] bus_a_v);
        wait_req();
        mif.mem_rdy  = 1'b1;
        mif.mem_data = word;
        tick();
        mif.mem_rdy  = 1'b0;
        mif.ex_done  = 1'b1;
        mif.bs       = bs_v;
        mif.ps       = ps_v;
        mif.z        = z_v;
        mif.bus_a    = bus_a_v;
        tick();
        mif.ex_done  = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        mif.mem_rdy  = 1'b1;
        mif.mem_data = 32'h1234_5678;
        mif.ex_done  = 1'b1;
        mif.bs       = 2'b10;
        mif.ps       = 1'b0;
        mif.z        = 1'b0;
        mif.bus_a    = 32'h0000_0099;
        tick();
        tick();
        tests_run += 4;
        if (mif.pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc: got %h want %h", mif.pc, 32'h0);
        end
        if (mif.ir_instruction !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ir: got %h want %h", mif.ir_instruction, 32'h0);
        end
        if (mif.ir_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ir_valid: got %b want 0", mif.ir_valid);
        end
        if (mif.mem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem_req: got %b want 0", mif.mem_req);
        end
        mif.mem_rdy = 1'b0;
        mif.ex_done = 1'b0;
        reset       = 1'b1;
        tick();
        tests_run += 2;
        if (mif.mem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL idle_to_fetch_req: got %b want 1", mif.mem_req);
        end
        if (mif.mem_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL idle_to_fetch_addr: got %h want %h", mif.mem_addr, 32'h0);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        mif.mem_rdy  = 1'b1;
        mif.mem_data = 32'h0;
        mif.ex_done  = 1'b1;
        mif.bs       = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            tests_run += 3;
            if (mif.mem_addr !== 32'(k)) begin
                tests_failed++;
                $display("[TB] FAIL stream_addr[%0d]: got %h want %h", k, mif.mem_addr, 32'(k));
            end
            if (mif.mem_req !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_req[%0d]: got %b want 1", k, mif.mem_req);
            end
            if (mif.ir_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stream_valid_low[%0d]: got %b want 0", k, mif.ir_valid);
            end
            tick();
            tests_run += 2;
            if (mif.ir_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_valid_high[%0d]: got %b want 1", k, mif.ir_valid);
            end
            if (mif.mem_req !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stream_req_low[%0d]: got %b want 0", k, mif.mem_req);
            end
            tick();
        end
        mif.mem_rdy = 1'b0;
        mif.ex_done = 1'b0;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mif.mem_data = 32'hA5A5_0003;
        mif.ex_done  = 1'b1;
        tick();
        mif.ex_done  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mif.mem_rdy = 1'b1;
            tests_run += 4;
            if (mif.mem_req !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL wait_req_stable[%0d]: got %b want 1", i, mif.mem_req);
            end
            if (mif.mem_addr !== 32'h0) begin
                tests_failed++;
                $display("[TB] FAIL wait_addr_stable[%0d]: got %h want %h", i, mif.mem_addr, 32'h0);
            end
            if (mif.ir_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL wait_valid_low[%0d]: got %b want 0", i, mif.ir_valid);
            end
            if (mif.ir_instruction !== 32'h0) begin
                tests_failed++;
                $display("[TB] FAIL wait_ir_held[%0d]: got %h want %h", i, mif.ir_instruction, 32'h0);
            end
            tick();
        end
        tests_run += 3;
        if (mif.ir_instruction !== 32'hA5A5_0003) begin
            tests_failed++;
            $display("[TB] FAIL wait_capture: got %h want %h", mif.ir_instruction, 32'hA5A5_0003);
        end
        if (mif.ir_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wait_capture_valid: got %b want 1", mif.ir_valid);
        end
        if (mif.mem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wait_capture_req: got %b want 0", mif.mem_req);
        end
        mif.mem_data = 32'h1111_2222;
        tick();
        tick();
        tests_run += 2;
        if (mif.ir_instruction !== 32'hA5A5_0003) begin
            tests_failed++;
            $display("[TB] FAIL issue_ignores_rdy: got %h want %h", mif.ir_instruction, 32'hA5A5_0003);
        end
        if (mif.ir_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL issue_holds_valid: got %b want 1", mif.ir_valid);
        end
        mif.mem_rdy = 1'b0;
    endtask

    task automatic test_branch();
        logic [1:0]  bs_vec [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
        logic        ps_vec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        z_vec  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_vec[4] = '{32'd9, 32'd11, 32'd9, 32'd11};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            issue(32'h0, 2'b10, 1'b0, 1'b0, 32'd10);
            issue(32'hFC00_7FFE, bs_vec[i], ps_vec[i], z_vec[i], 32'hDEAD_0000);
            tests_run += 2;
            if (mif.pc !== exp_vec[i]) begin
                tests_failed++;
                $display("[TB] FAIL branch_pc[%0d]: got %h want %h", i, mif.pc, exp_vec[i]);
            end
            if (mif.mem_addr !== exp_vec[i]) begin
                tests_failed++;
                $display("[TB] FAIL branch_addr[%0d]: got %h want %h", i, mif.mem_addr, exp_vec[i]);
            end
        end
    endtask

    task automatic test_jump();
        apply_reset();
        issue(32'h0000_0003, 2'b10, 1'b1, 1'b1, 32'h0000_0040);
        tests_run++;
        if (mif.mem_addr !== 32'h0000_0040) begin
            tests_failed++;
            $display("[TB] FAIL jump_abs: got %h want %h", mif.mem_addr, 32'h0000_0040);
        end
        issue(32'h0, 2'b10, 1'b0, 1'b0, 32'd8);
        issue(32'hFE00_0005, 2'b11, 1'b0, 1'b0, 32'h0000_0040);
        tests_run++;
        if (mif.pc !== 32'd14) begin
            tests_failed++;
            $display("[TB] FAIL jump_rel: got %h want %h", mif.pc, 32'd14);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        issue(32'h0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tests_run++;
        if (mif.pc !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL wrap_setup: got %h want %h", mif.pc, 32'hFFFF_FFFF);
        end
        issue(32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (mif.pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_pc: got %h want %h", mif.pc, 32'h0);
        end
        wait_req();
        mif.mem_rdy = 1'b1;
        tick();
        mif.mem_rdy = 1'b0;
        mif.ex_done = 1'b1;
        mif.bs      = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        mif.ex_done = 1'b0;
        tests_run += 2;
        if (mif.pc !== 32'h1) begin
            tests_failed++;
            $display("[TB] FAIL held_ex_done_pc: got %h want %h", mif.pc, 32'h1);
        end
        if (mif.mem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL held_ex_done_req: got %b want 1", mif.mem_req);
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        issue(32'h0, 2'b10, 1'b0, 1'b0, 32'd5);
        mif.mem_rdy  = 1'b1;
        mif.mem_data = 32'hDEAD_BEEF;
        reset        = 1'b0;
        tick();
        tests_run += 4;
        if (mif.ir_instruction !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL abort_fetch_ir: got %h want %h", mif.ir_instruction, 32'h0);
        end
        if (mif.ir_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_fetch_valid: got %b want 0", mif.ir_valid);
        end
        if (mif.pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL abort_fetch_pc: got %h want %h", mif.pc, 32'h0);
        end
        if (mif.mem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_fetch_req: got %b want 0", mif.mem_req);
        end
        mif.mem_rdy = 1'b0;
        reset       = 1'b1;
        tick();
        tests_run += 2;
        if (mif.mem_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL restart_addr: got %h want %h", mif.mem_addr, 32'h0);
        end
        if (mif.mem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL restart_req: got %b want 1", mif.mem_req);
        end
        issue(32'h0, 2'b10, 1'b0, 1'b0, 32'd6);
        wait_req();
        mif.mem_rdy  = 1'b1;
        mif.mem_data = 32'h0BAD_0001;
        tick();
        mif.mem_rdy  = 1'b0;
        mif.ex_done  = 1'b1;
        mif.bs       = 2'b10;
        mif.bus_a    = 32'h0000_0077;
        reset        = 1'b0;
        tick();
        mif.ex_done  = 1'b0;
        reset        = 1'b1;
        tests_run += 2;
        if (mif.pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL abort_issue_pc: got %h want %h", mif.pc, 32'h0);
        end
        if (mif.ir_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_issue_valid: got %b want 0", mif.ir_valid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_mem_wait();
        test_branch();
        test_jump();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
